// File: rtl/uart_bus_responder.sv
// Memory-mapped UART on the MEM-stage load/store bus: TX holding register, RX FIFO,
// control/status register and a level interrupt. Loads are answered combinationally.
module uart_bus_responder #(
    parameter int BAUD_DIV   = 10417,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CNT_W  = $clog2(BAUD_DIV);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    // Bus decode
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd;
    logic unused_wdata;

    assign sel_txd      = (Addr == ADDR_TXD);
    assign sel_rxd      = (Addr == ADDR_RXD);
    assign sel_con      = (Addr == ADDR_CON);
    assign wr_txd       = MemWr & sel_txd;
    assign wr_con       = MemWr & sel_con;
    assign rd_rxd       = MemRd & sel_rxd;
    assign unused_wdata = ^WriteData[31:8];

    // Transmitter
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_pend;
    logic             tx_busy;
    logic             tx_tick, tx_accept, tx_reject, tx_finish;

    assign tx_tick   = (tx_cnt == BIT_LAST);
    assign tx_accept = wr_txd & ~tx_busy & ~tx_pend;
    assign tx_reject = wr_txd & (tx_busy | tx_pend);
    assign tx_finish = (tx_state == TX_STOP) & tx_tick;

    // The accepted byte waits one cycle in tx_pend before the start bit goes out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_pend  <= 1'b0;
            tx_busy  <= 1'b0;
            UART_TX  <= 1'b1;
        end else begin
            if (tx_accept)
                tx_pend <= 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pend) begin
                        tx_state <= TX_START;
                        tx_cnt   <= '0;
                        tx_pend  <= 1'b0;
                        tx_busy  <= 1'b1;
                        UART_TX  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        UART_TX  <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            UART_TX  <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            UART_TX <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_state <= TX_IDLE;
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_accept)
            tx_shift <= WriteData[7:0];
        else if ((tx_state == TX_DATA) && tx_tick)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // Receiver: two-flop synchronizer plus one more flop for falling-edge detection
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_s1, rx_s2, rx_s2_d;
    logic             rx_fall, rx_tick, rx_stop_smp, rx_push, rx_ferr_set;

    assign rx_fall     = rx_s2_d & ~rx_s2;
    assign rx_tick     = (rx_cnt == BIT_LAST);
    assign rx_stop_smp = (rx_state == RX_STOP) & rx_tick;
    assign rx_push     = rx_stop_smp & rx_s2;
    assign rx_ferr_set = rx_stop_smp & ~rx_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s2_d  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1   <= UART_RX;
            rx_s2   <= rx_s1;
            rx_s2_d <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_state <= RX_IDLE;
                        rx_cnt   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((rx_state == RX_DATA) && rx_tick)
            rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    // Receive FIFO; a pop in the same cycle frees the slot for an incoming byte
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_empty, fifo_full, fifo_pop, fifo_push, rx_ovr_set;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign fifo_pop   = rd_rxd & ~fifo_empty;
    assign fifo_push  = rx_push & (~fifo_full | fifo_pop);
    assign rx_ovr_set = rx_push & fifo_full & ~fifo_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= rx_shift;
    end

    // Control/status flags; a hardware set beats a same-cycle software clear
    logic rx_overrun, tx_drop, frame_err, tx_done, rx_irq_en, tx_irq_en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
            frame_err  <= 1'b0;
            tx_done    <= 1'b0;
            rx_irq_en  <= 1'b0;
            tx_irq_en  <= 1'b0;
        end else begin
            rx_overrun <= rx_ovr_set  | (rx_overrun & ~(wr_con & WriteData[2]));
            tx_drop    <= tx_reject   | (tx_drop    & ~(wr_con & WriteData[3]));
            frame_err  <= rx_ferr_set | (frame_err  & ~(wr_con & WriteData[6]));
            tx_done    <= tx_finish   | (tx_done    & ~(wr_con & WriteData[7]) & ~tx_accept);
            if (wr_con) begin
                rx_irq_en <= WriteData[4];
                tx_irq_en <= WriteData[5];
            end
        end
    end

    logic [7:0] con_val;
    assign con_val = {tx_done, frame_err, tx_irq_en, rx_irq_en,
                      tx_drop, rx_overrun, ~fifo_empty, tx_busy};

    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            if (sel_rxd)
                ReadData = {24'b0, fifo_empty ? 8'h00 : fifo_mem[rd_ptr]};
            else if (sel_con)
                ReadData = {24'b0, con_val};
        end
    end

    assign irq = (rx_irq_en & ~fifo_empty) | (tx_irq_en & tx_done);

endmodule
